lb_uart_rx_engine: RTL and testbench
====================================

// Module: lb_uart_rx_engine
// PURPOSE
//  UART receiver, the counterpart of the team's UART transmitter top level. It uses the same frame controls
//  (bit8, parity_en, odd_n_even, baud_val), so a looped-back TX/RX pair exchanges bytes unchanged.
//  It oversamples rx at 16x the baud rate, deframes start/data/parity/stop, and holds one received byte.
//  That byte is read by the host over the local bus (cs/rd) and is flagged with parity, framing and overrun errors.
// PARAMETERS
//  CLK_FREQ  100_000_000  system clock frequency in Hz; sets the 16x divisor table
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  synchronous, active-high reset
//  cs          in   1  chip select, active-high
//  rd          in   1  read strobe; cs&rd for one clk = host consumed byte
//  rx          in   1  serial input, asynchronous, idles high
//  bit8        in   1  1: 8 data bits; 0: 7 data bits
//  parity_en   in   1  1: parity bit follows the data bits
//  odd_n_even  in   1  1: odd parity; 0: even parity
//  baud_val    in   4  baud select (see BEHAVIOUR)
//  data        out  8  last received byte; bit7=0 in 7-bit mode
//  rxrdy       out  1  unread byte held in data
//  perr        out  1  parity error on the held byte
//  ferr        out  1  framing error (stop bit sampled 0) on the held byte
//  ovf         out  1  a byte completed while rxrdy was still 1
// BEHAVIOUR
//  - Reset values: data=0, rxrdy=0, perr=0, ferr=0, ovf=0; state=IDLE; both rx sync flops=1; counters=0.
//  - rx passes through a 2-flop synchroniser. All logic uses the synchronised value rxs.
//  - Baud select: baud_val 0..11 = 300,1200,2400,4800,9600,19200,38400,57600,115200,230400,460800,921600.
//    Codes 12..15 = 921600.
//  - 16x tick period = round(CLK_FREQ/(16*baud)) clocks; at 100 MHz, 115200 gives 54.
//  - bit8, parity_en, odd_n_even and baud_val are latched at start detection and held for the whole frame.
//  - FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
//    IDLE: on rxs=0, clear the tick divider and the 16x sample counter, then go to START.
//    START: on tick 8 (mid-bit), if rxs=1 it is a false start -> IDLE, no flags touched; otherwise -> DATA.
//    DATA: sample every 16 ticks, LSB first; 8 or 7 bits; then -> PARITY if enabled, else -> STOP.
//    PARITY: sample 16 ticks later. Expected bit = XOR(data bits) ^ odd_n_even.
//    STOP: sample 16 ticks later; on this same clock edge the frame completes and the FSM -> IDLE.
//  - Frame completion, done on one edge:
//    data <= assembled byte; rxrdy <= 1; perr, ferr <= this frame's result.
//    ovf <= 1 if rxrdy was 1 and no read is occurring this cycle; otherwise ovf keeps its value.
//  - A byte with ferr=1 is still stored and rxrdy is still set.
//  - After a 0 stop bit, the FSM waits in IDLE for rxs=1 before it arms a new start. This avoids retriggering on break.
//  - Read: cs&rd clears rxrdy, perr, ferr and ovf on the next edge; data is held. A read while rxrdy=0 has no effect.
//  - Read and frame completion on the same edge: the completion wins. rxrdy stays 1, flags take the new frame's values, ovf=0.
//  - Reset in mid-frame aborts the frame; there is no partial update of data.
//  - Latency: rxrdy rises (1.5 + N + P) bit periods after the rxs falling edge (±1 tick). N = 7/8, P = parity_en.
//    Add 2 clocks for the synchroniser, measured from the rx pin.
// TESTING
//  1. baud_val=8, bit8=1, parity_en=1, odd_n_even=1; send 0xA5 with parity bit 1 and stop=1
//     -> data=0xA5, rxrdy=1, perr=0, ferr=0, ovf=0.
//  2. Same config, send 0xA5 with parity bit 0 -> data=0xA5, rxrdy=1, perr=1.
//     Then pulse cs&rd for 1 clk -> rxrdy=0, perr=0, data still 0xA5.
//  3. bit8=0, parity_en=0; send 7-bit 0x55 with stop=0 -> data=0x55, ferr=1.
//     Hold rx=0 for 3 bit times -> no new frame until rx returns to 1.
//  4. Send 0x3C and then 0xC3 with no read in between -> data=0xC3, rxrdy=1, ovf=1.
//     Repeat with cs&rd asserted exactly on the second completion edge -> ovf=0, rxrdy=1.
//  5. Drive a 4-tick low glitch on rx -> FSM returns to IDLE, rxrdy stays 0, all flags 0.
//  6. Assert reset halfway through a frame's data bits, release it, send 0x81
//     -> outputs 0 during reset; afterwards data=0x81 with no corruption.

Source files
------------

// File: rtl/lb_uart_rx_engine_if.sv
// Host-side local bus of the UART receiver.
//   cs, rd      : host chip select and read strobe (cs&rd for one clk consumes the byte)
//   data        : last received byte
//   rxrdy       : an unread byte is held in data
//   perr/ferr   : parity / framing error of the held byte
//   ovf         : a byte completed while the previous one was still unread
// master = host, slave = receiver.
interface lb_uart_rx_engine_if;
  logic       cs;
  logic       rd;
  logic [7:0] data;
  logic       rxrdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  modport master (output cs, rd, input data, rxrdy, perr, ferr, ovf);
  modport slave  (input cs, rd, output data, rxrdy, perr, ferr, ovf);
endinterface

// File: rtl/lb_uart_rx_engine.sv
// UART receiver. Oversamples rx at 16x the selected baud rate, deframes
// start / 7-8 data bits / optional parity / stop, and holds one byte for the
// host, tagged with parity, framing and overrun errors.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   bus          : host local bus (cs/rd in; data/rxrdy/perr/ferr/ovf out)
//   rx           : asynchronous serial input, idles high
//   bit8         : 1 = 8 data bits, 0 = 7 data bits
//   parity_en    : parity bit follows data
//   odd_n_even   : 1 = odd parity, 0 = even
//   baud_val     : baud select, 0..11 = 300..921600, 12..15 = 921600
module lb_uart_rx_engine #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  lb_uart_rx_engine_if.slave   bus,
  input  logic                 rx,
  input  logic                 bit8,
  input  logic                 parity_en,
  input  logic                 odd_n_even,
  input  logic [3:0]           baud_val
);

  // round(CLK_FREQ / (16*baud)), never below one clock
  function automatic int div_of(input int baud);
    int d;
    d = (CLK_FREQ + 8 * baud) / (16 * baud);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic [11:0][31:0] build_tab();
    logic [11:0][31:0] t;
    t[0]  = 32'(div_of(300));
    t[1]  = 32'(div_of(1200));
    t[2]  = 32'(div_of(2400));
    t[3]  = 32'(div_of(4800));
    t[4]  = 32'(div_of(9600));
    t[5]  = 32'(div_of(19200));
    t[6]  = 32'(div_of(38400));
    t[7]  = 32'(div_of(57600));
    t[8]  = 32'(div_of(115200));
    t[9]  = 32'(div_of(230400));
    t[10] = 32'(div_of(460800));
    t[11] = 32'(div_of(921600));
    return t;
  endfunction

  localparam logic [11:0][31:0] DIV_TAB = build_tab();
  localparam int DW = $clog2(div_of(300) + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_n;
  logic [1:0]      rx_sync;
  logic            rxs;
  logic            bit8_q, par_en_q, odd_q;
  logic [3:0]      baud_q;
  logic [DW-1:0]   div_val, div_cnt;
  logic [3:0]      s_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg, asm_byte;
  logic            par_bad;
  logic            brk_wait;
  logic [7:0]      data_q;
  logic            rxrdy_q, perr_q, ferr_q, ovf_q;
  logic            tick, mid_tick, end_tick;
  logic            start_det, shift_en, par_smp, done;
  logic            rd_eff;

  assign rxs = rx_sync[1];

  always_comb begin
    div_val = DIV_TAB[11][DW-1:0];
    if (baud_q < 4'd12) div_val = DIV_TAB[baud_q][DW-1:0];
  end

  assign tick     = (state_q != IDLE) && (div_cnt == div_val - DW'(1));
  assign mid_tick = tick && (s_cnt == 4'd7);
  assign end_tick = tick && (s_cnt == 4'd15);
  // 7-bit frames leave the byte in shreg[7:1]
  assign asm_byte = bit8_q ? shreg : {1'b0, shreg[7:1]};
  assign rd_eff   = bus.cs && bus.rd && rxrdy_q;

  // next state and per-cycle strobes
  always_comb begin
    state_n   = state_q;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_smp   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:   if (!rxs && !brk_wait) begin
                start_det = 1'b1;
                state_n   = START;
              end
      START:  if (mid_tick) state_n = rxs ? IDLE : DATA;
      DATA:   if (end_tick) begin
                shift_en = 1'b1;
                if (bit_cnt == (bit8_q ? 3'd7 : 3'd6))
                  state_n = par_en_q ? PARITY : STOP;
              end
      PARITY: if (end_tick) begin
                par_smp = 1'b1;
                state_n = STOP;
              end
      STOP:   if (end_tick) begin
                done    = 1'b1;
                state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      bit8_q   <= 1'b0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      baud_q   <= '0;
      div_cnt  <= '0;
      s_cnt    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      brk_wait <= 1'b0;
      data_q   <= '0;
      rxrdy_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};

      if (start_det) begin
        bit8_q   <= bit8;
        par_en_q <= parity_en;
        odd_q    <= odd_n_even;
        baud_q   <= baud_val;
        div_cnt  <= '0;
        s_cnt    <= '0;
        bit_cnt  <= '0;
        par_bad  <= 1'b0;
      end else if (state_q != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        // realign the 16x phase to mid-bit once the start bit is confirmed
        if (state_q == START && mid_tick) s_cnt <= '0;
        else if (tick)                    s_cnt <= s_cnt + 4'd1;
      end

      if (shift_en) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_smp) par_bad <= rxs ^ (^asm_byte) ^ odd_q;

      // a low stop bit may be a break: re-arm only after the line goes high
      if (state_q == IDLE && rxs) brk_wait <= 1'b0;

      if (done) begin
        data_q   <= asm_byte;
        rxrdy_q  <= 1'b1;
        perr_q   <= par_bad;
        ferr_q   <= !rxs;
        brk_wait <= !rxs;
        if (rd_eff)       ovf_q <= 1'b0;
        else if (rxrdy_q) ovf_q <= 1'b1;
      end else if (rd_eff) begin
        rxrdy_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end
    end
  end

  assign bus.data  = data_q;
  assign bus.rxrdy = rxrdy_q;
  assign bus.perr  = perr_q;
  assign bus.ferr  = ferr_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_lb_uart_rx_engine.sv
module tb_lb_uart_rx_engine;
  // 115200 baud (code 8) gives a 16x divisor of 4 -> 64 clocks per bit
  localparam int CLK_FREQ = 7_372_800;
  localparam int BIT      = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx, bit8, parity_en, odd_n_even;
  logic [3:0] baud_val;
  int         errors = 0;
  int         checks = 0;

  lb_uart_rx_engine_if bus();

  lb_uart_rx_engine #(.CLK_FREQ(CLK_FREQ)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .baud_val(baud_val)
  );

  always #5 clk = ~clk;

  initial begin
    #600_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit par_of(input logic [7:0] d, input bit odd);
    return (^d) ^ odd;
  endfunction

  // called at a negedge; leaves rx at the stop value
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pv, input bit sv);
    rx = 1'b0; hold(BIT);
    for (int i = 0; i < nb; i++) begin rx = d[i]; hold(BIT); end
    if (pen) begin rx = pv; hold(BIT); end
    rx = sv; hold(BIT);
  endtask

  task automatic do_read;
    bus.cs = 1'b1; bus.rd = 1'b1; hold(1);
    bus.cs = 1'b0; bus.rd = 1'b0; hold(1);
  endtask

  task automatic test_reset;
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", bus.data); end
    checks++; if (bus.rxrdy !== 1'b0) begin errors++; $display("FAIL rst_rxrdy got=%b exp=0", bus.rxrdy); end
    checks++; if (bus.perr !== 1'b0) begin errors++; $display("FAIL rst_perr got=%b exp=0", bus.perr); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b exp=0", bus.ferr); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf); end
  endtask

  task automatic test_good_parity;
    bit8 = 1; parity_en = 1; odd_n_even = 1; baud_val = 4'd8;
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL t1_data got=%h exp=a5", bus.data); end
    checks++; if (bus.rxrdy !== 1'b1) begin errors++; $display("FAIL t1_rxrdy got=%b exp=1", bus.rxrdy); end
    checks++; if (bus.perr !== 1'b0) begin errors++; $display("FAIL t1_perr got=%b exp=0", bus.perr); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL t1_ferr got=%b exp=0", bus.ferr); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL t1_ovf got=%b exp=0", bus.ovf); end
    do_read;
  endtask

  task automatic test_bad_parity;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL t2_data got=%h exp=a5", bus.data); end
    checks++; if (bus.rxrdy !== 1'b1) begin errors++; $display("FAIL t2_rxrdy got=%b exp=1", bus.rxrdy); end
    checks++; if (bus.perr !== 1'b1) begin errors++; $display("FAIL t2_perr got=%b exp=1", bus.perr); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL t2_ovf got=%b exp=0", bus.ovf); end
    do_read;
    checks++; if (bus.rxrdy !== 1'b0) begin errors++; $display("FAIL t2_rd_rxrdy got=%b exp=0", bus.rxrdy); end
    checks++; if (bus.perr !== 1'b0) begin errors++; $display("FAIL t2_rd_perr got=%b exp=0", bus.perr); end
    checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL t2_rd_data got=%h exp=a5", bus.data); end
  endtask

  task automatic test_break;
    bit8 = 0; parity_en = 0;
    send_frame(8'h55, 7, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.data !== 8'h55) begin errors++; $display("FAIL t3_data got=%h exp=55", bus.data); end
    checks++; if (bus.ferr !== 1'b1) begin errors++; $display("FAIL t3_ferr got=%b exp=1", bus.ferr); end
    checks++; if (bus.rxrdy !== 1'b1) begin errors++; $display("FAIL t3_rxrdy got=%b exp=1", bus.rxrdy); end
    do_read;
    hold(10 * BIT);
    checks++; if (bus.rxrdy !== 1'b0) begin errors++; $display("FAIL t3_break_rxrdy got=%b exp=0", bus.rxrdy); end
    rx = 1'b1; hold(2 * BIT);
    checks++; if (bus.rxrdy !== 1'b0) begin errors++; $display("FAIL t3_idle_rxrdy got=%b exp=0", bus.rxrdy); end
    send_frame(8'h2A, 7, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.data !== 8'h2A) begin errors++; $display("FAIL t3_rearm_data got=%h exp=2a", bus.data); end
    checks++; if (bus.ferr !== 1'b0) begin errors++; $display("FAIL t3_rearm_ferr got=%b exp=0", bus.ferr); end
    do_read;
  endtask

  task automatic test_back_to_back;
    bit8 = 1; parity_en = 1; odd_n_even = 1;
    send_frame(8'h3C, 8, 1'b1, par_of(8'h3C, 1'b1), 1'b1);
    send_frame(8'hC3, 8, 1'b1, par_of(8'hC3, 1'b1), 1'b1);
    checks++; if (bus.data !== 8'hC3) begin errors++; $display("FAIL t4_data got=%h exp=c3", bus.data); end
    checks++; if (bus.rxrdy !== 1'b1) begin errors++; $display("FAIL t4_rxrdy got=%b exp=1", bus.rxrdy); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL t4_ovf got=%b exp=1", bus.ovf); end
    do_read;
    send_frame(8'h3C, 8, 1'b1, par_of(8'h3C, 1'b1), 1'b1);
    // completion is the 168th 16x tick after start detection, which lands
    // on the 675th rising edge after rx falls (2 sync + 1 detect + 4*168)
    fork
      send_frame(8'hC3, 8, 1'b1, par_of(8'hC3, 1'b1), 1'b1);
      begin
        hold(674);
        bus.cs = 1'b1; bus.rd = 1'b1; hold(1);
        bus.cs = 1'b0; bus.rd = 1'b0;
      end
    join
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL t4_rdc_ovf got=%b exp=0", bus.ovf); end
    checks++; if (bus.rxrdy !== 1'b1) begin errors++; $display("FAIL t4_rdc_rxrdy got=%b exp=1", bus.rxrdy); end
    checks++; if (bus.data !== 8'hC3) begin errors++; $display("FAIL t4_rdc_data got=%h exp=c3", bus.data); end
    do_read;
  endtask

  task automatic test_glitch;
    rx = 1'b0; hold(16);
    rx = 1'b1; hold(3 * BIT);
    checks++; if (bus.rxrdy !== 1'b0) begin errors++; $display("FAIL t5_rxrdy got=%b exp=0", bus.rxrdy); end
    checks++; if ({bus.perr, bus.ferr, bus.ovf} !== 3'b000) begin errors++; $display("FAIL t5_flags got=%b exp=000", {bus.perr, bus.ferr, bus.ovf}); end
    checks++; if (bus.data !== 8'hC3) begin errors++; $display("FAIL t5_data got=%h exp=c3", bus.data); end
  endtask

  task automatic test_reset_mid;
    send_frame(8'h5A, 8, 1'b1, par_of(8'h5A, 1'b1), 1'b1);
    rx = 1'b0; hold(BIT);
    rx = 1'b1; hold(2 * BIT);
    rx = 1'b0; hold(2 * BIT + BIT / 2);
    reset = 1'b1; rx = 1'b1; hold(4);
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL t6_rst_data got=%h exp=00", bus.data); end
    checks++; if (bus.rxrdy !== 1'b0) begin errors++; $display("FAIL t6_rst_rxrdy got=%b exp=0", bus.rxrdy); end
    checks++; if ({bus.perr, bus.ferr, bus.ovf} !== 3'b000) begin errors++; $display("FAIL t6_rst_flags got=%b exp=000", {bus.perr, bus.ferr, bus.ovf}); end
    reset = 1'b0; hold(2 * BIT);
    checks++; if (bus.rxrdy !== 1'b0) begin errors++; $display("FAIL t6_post_rxrdy got=%b exp=0", bus.rxrdy); end
    send_frame(8'h81, 8, 1'b1, par_of(8'h81, 1'b1), 1'b1);
    checks++; if (bus.data !== 8'h81) begin errors++; $display("FAIL t6_data got=%h exp=81", bus.data); end
    checks++; if (bus.rxrdy !== 1'b1) begin errors++; $display("FAIL t6_rxrdy got=%b exp=1", bus.rxrdy); end
    checks++; if ({bus.perr, bus.ferr, bus.ovf} !== 3'b000) begin errors++; $display("FAIL t6_flags got=%b exp=000", {bus.perr, bus.ferr, bus.ovf}); end
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; bus.cs = 1'b0; bus.rd = 1'b0;
    bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b1; baud_val = 4'd8;
    hold(5);
    test_reset;
    reset = 1'b0;
    hold(2 * BIT);
    test_good_parity;
    test_bad_parity;
    test_break;
    test_back_to_back;
    test_glitch;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
